// File: rtl/data_mem_arbiter_if.sv
// Valid/ready data-memory port bundle, NUM_PORTS lanes wide.
// The arbiter uses one instance toward the LSUs (slave) and one toward memory (master).
interface data_mem_arbiter_if #(
   parameter int ADDR_BITS = 8,
   parameter int DATA_BITS = 32,
   parameter int NUM_PORTS = 8
);
   logic [NUM_PORTS-1:0]                read_valid;
   logic [NUM_PORTS-1:0][ADDR_BITS-1:0] read_address;
   logic [NUM_PORTS-1:0]                read_ready;
   logic [NUM_PORTS-1:0][DATA_BITS-1:0] read_data;
   logic [NUM_PORTS-1:0]                write_valid;
   logic [NUM_PORTS-1:0][ADDR_BITS-1:0] write_address;
   logic [NUM_PORTS-1:0][DATA_BITS-1:0] write_data;
   logic [NUM_PORTS-1:0]                write_ready;

   modport master (
      output read_valid, read_address, write_valid, write_address, write_data,
      input  read_ready, read_data, write_ready
   );

   modport slave (
      input  read_valid, read_address, write_valid, write_address, write_data,
      output read_ready, read_data, write_ready
   );
endinterface

// File: rtl/data_mem_arbiter.sv
// Round-robin sharing of NUM_CHANNELS data-memory channels among NUM_CONSUMERS LSU requesters.
// Write path is built only when DATA_MEM_ARB_WRITE_EN is defined; otherwise the arbiter is read-only.
module data_mem_arbiter #(
   parameter int ADDR_BITS     = 8,
   parameter int DATA_BITS     = 32,
   parameter int NUM_CONSUMERS = 8,
   parameter int NUM_CHANNELS  = 2
) (
   input logic                clk,
   input logic                reset,
   data_mem_arbiter_if.slave  consumer,
   data_mem_arbiter_if.master mem
);
   localparam int CW = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;

   typedef enum logic [2:0] {
      IDLE          = 3'd0,
      READ_WAITING  = 3'd1,
      WRITE_WAITING = 3'd2,
      RELAYING      = 3'd3
   } state_e;

   state_e                                  state_q [NUM_CHANNELS];
   logic [CW-1:0]                           cur_q   [NUM_CHANNELS];
   logic                                    op_wr_q [NUM_CHANNELS];
   logic [NUM_CONSUMERS-1:0]                serving_q;
   logic [CW-1:0]                           rr_q;

   logic [NUM_CHANNELS-1:0]                 mem_rvalid_q;
   logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]  mem_raddr_q;
   logic [NUM_CONSUMERS-1:0]                cons_rready_q;
   logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] cons_rdata_q;
`ifdef DATA_MEM_ARB_WRITE_EN
   logic [NUM_CHANNELS-1:0]                 mem_wvalid_q;
   logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]  mem_waddr_q;
   logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]  mem_wdata_q;
   logic [NUM_CONSUMERS-1:0]                cons_wready_q;
`endif

   logic [NUM_CONSUMERS-1:0]                req_rd;
   logic [NUM_CONSUMERS-1:0]                req_wr;
   logic [NUM_CHANNELS-1:0]                 gnt_vld_d;
   logic [NUM_CHANNELS-1:0]                 gnt_rd_d;
   logic [CW-1:0]                           gnt_idx_d [NUM_CHANNELS];
   logic [CW-1:0]                           rr_d;

   assign req_rd = consumer.read_valid;
`ifdef DATA_MEM_ARB_WRITE_EN
   assign req_wr = consumer.write_valid;
`else
   assign req_wr = '0;
`endif

   // Channels allocate in ascending order; each one skips consumers already claimed this cycle.
   always_comb begin
      logic [NUM_CONSUMERS-1:0] claimed;
      logic [CW-1:0]            sel;
      int                       idx;
      claimed   = serving_q;
      sel       = '0;
      idx       = 0;
      rr_d      = rr_q;
      gnt_vld_d = '0;
      gnt_rd_d  = '0;
      for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
         gnt_idx_d[ch] = '0;
         if (state_q[ch] == IDLE) begin
            for (int k = 0; k < NUM_CONSUMERS; k++) begin
               idx = int'(rr_q) + k;
               if (idx >= NUM_CONSUMERS) idx = idx - NUM_CONSUMERS;
               sel = CW'(idx);
               if (!gnt_vld_d[ch] && !claimed[sel] && (req_rd[sel] || req_wr[sel])) begin
                  gnt_vld_d[ch] = 1'b1;
                  gnt_rd_d[ch]  = req_rd[sel];
                  gnt_idx_d[ch] = sel;
                  claimed[sel]  = 1'b1;
                  rr_d          = (idx == NUM_CONSUMERS - 1) ? '0 : CW'(idx + 1);
               end
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
            state_q[ch] <= IDLE;
            cur_q[ch]   <= '0;
            op_wr_q[ch] <= 1'b0;
         end
         serving_q     <= '0;
         rr_q          <= '0;
         mem_rvalid_q  <= '0;
         mem_raddr_q   <= '0;
         cons_rready_q <= '0;
         cons_rdata_q  <= '0;
`ifdef DATA_MEM_ARB_WRITE_EN
         mem_wvalid_q  <= '0;
         mem_waddr_q   <= '0;
         mem_wdata_q   <= '0;
         cons_wready_q <= '0;
`endif
      end else begin
         rr_q <= rr_d;
         for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
            case (state_q[ch])
               IDLE: begin
                  if (gnt_vld_d[ch]) begin
                     cur_q[ch]                 <= gnt_idx_d[ch];
                     serving_q[gnt_idx_d[ch]]  <= 1'b1;
                     if (gnt_rd_d[ch]) begin
                        op_wr_q[ch]      <= 1'b0;
                        mem_rvalid_q[ch] <= 1'b1;
                        mem_raddr_q[ch]  <= consumer.read_address[gnt_idx_d[ch]];
                        state_q[ch]      <= READ_WAITING;
                     end
`ifdef DATA_MEM_ARB_WRITE_EN
                     else begin
                        op_wr_q[ch]      <= 1'b1;
                        mem_wvalid_q[ch] <= 1'b1;
                        mem_waddr_q[ch]  <= consumer.write_address[gnt_idx_d[ch]];
                        mem_wdata_q[ch]  <= consumer.write_data[gnt_idx_d[ch]];
                        state_q[ch]      <= WRITE_WAITING;
                     end
`endif
                  end
               end
               READ_WAITING: begin
                  if (mem.read_ready[ch]) begin
                     mem_rvalid_q[ch]           <= 1'b0;
                     cons_rdata_q[cur_q[ch]]    <= mem.read_data[ch];
                     cons_rready_q[cur_q[ch]]   <= 1'b1;
                     state_q[ch]                <= RELAYING;
                  end
               end
               WRITE_WAITING: begin
`ifdef DATA_MEM_ARB_WRITE_EN
                  if (mem.write_ready[ch]) begin
                     mem_wvalid_q[ch]         <= 1'b0;
                     cons_wready_q[cur_q[ch]] <= 1'b1;
                     state_q[ch]              <= RELAYING;
                  end
`else
                  state_q[ch] <= IDLE;
`endif
               end
               RELAYING: begin
                  // Release waits on the valid of the operation actually served, not the other one.
                  if (op_wr_q[ch] ? !consumer.write_valid[cur_q[ch]]
                                  : !consumer.read_valid[cur_q[ch]]) begin
                     cons_rready_q[cur_q[ch]] <= 1'b0;
`ifdef DATA_MEM_ARB_WRITE_EN
                     cons_wready_q[cur_q[ch]] <= 1'b0;
`endif
                     serving_q[cur_q[ch]]     <= 1'b0;
                     state_q[ch]              <= IDLE;
                  end
               end
               default: state_q[ch] <= IDLE;
            endcase
         end
      end
   end

   assign mem.read_valid       = mem_rvalid_q;
   assign mem.read_address     = mem_raddr_q;
   assign consumer.read_ready  = cons_rready_q;
   assign consumer.read_data   = cons_rdata_q;
`ifdef DATA_MEM_ARB_WRITE_EN
   assign mem.write_valid      = mem_wvalid_q;
   assign mem.write_address    = mem_waddr_q;
   assign mem.write_data       = mem_wdata_q;
   assign consumer.write_ready = cons_wready_q;
`else
   assign mem.write_valid      = '0;
   assign mem.write_address    = '0;
   assign mem.write_data       = '0;
   assign consumer.write_ready = '0;

   logic unused_write;
   assign unused_write = ^{consumer.write_valid, consumer.write_address,
                           consumer.write_data, mem.write_ready};
`endif
endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: directed scenarios plus randomized traffic against a memory/consumer model.
module tb_data_mem_arbiter;
   localparam int AB  = 8;
   localparam int DB  = 32;
   localparam int NC  = 8;
   localparam int NCH = 2;
`ifdef DATA_MEM_ARB_WRITE_EN
   localparam bit WR_EN = 1'b1;
`else
   localparam bit WR_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   data_mem_arbiter_if #(.ADDR_BITS(AB), .DATA_BITS(DB), .NUM_PORTS(NC))  cif ();
   data_mem_arbiter_if #(.ADDR_BITS(AB), .DATA_BITS(DB), .NUM_PORTS(NCH)) mif ();

   data_mem_arbiter #(
      .ADDR_BITS(AB), .DATA_BITS(DB), .NUM_CONSUMERS(NC), .NUM_CHANNELS(NCH)
   ) dut (
      .clk(clk), .reset(reset), .consumer(cif), .mem(mif)
   );

   int n_chk = 0;
   int n_err = 0;

   logic [DB-1:0] mem_arr [256];
   logic [DB-1:0] ref_mem [256];
   bit mem_hold = 1'b0;
   int lat_lo   = 0;
   int lat_hi   = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [DB-1:0] init_word(input int a);
      logic [DB-1:0] w;
      w = 32'h9E37_79B9 * 32'(a + 1);
      return (a == 'h10) ? 32'h0001_8000 : w;
   endfunction

   task automatic check_zero(input string tag);
      check({tag, "_crready"}, 64'(cif.read_ready), 64'(0));
      check({tag, "_crdata"},  64'(|cif.read_data), 64'(0));
      check({tag, "_cwready"}, 64'(cif.write_ready), 64'(0));
      check({tag, "_mrvalid"}, 64'(mif.read_valid), 64'(0));
      check({tag, "_mraddr"},  64'(|mif.read_address), 64'(0));
      check({tag, "_mwvalid"}, 64'(mif.write_valid), 64'(0));
      check({tag, "_mwaddr"},  64'(|mif.write_address), 64'(0));
      check({tag, "_mwdata"},  64'(|mif.write_data), 64'(0));
   endtask

   // Memory: answers a request after a per-transaction latency drawn from [lat_lo, lat_hi].
   initial begin : mem_model
      int rcnt [NCH];
      int wcnt [NCH];
      int rlat [NCH];
      int wlat [NCH];
      for (int i = 0; i < 256; i++) mem_arr[i] = init_word(i);
      mif.read_ready  = '0;
      mif.read_data   = '0;
      mif.write_ready = '0;
      for (int ch = 0; ch < NCH; ch++) begin
         rcnt[ch] = 0; wcnt[ch] = 0; rlat[ch] = 0; wlat[ch] = 0;
      end
      forever begin
         @(posedge clk);
         #1;
         for (int ch = 0; ch < NCH; ch++) begin
            if (mif.read_valid[ch] && !mem_hold) begin
               rcnt[ch]++;
               if (rcnt[ch] == 1) rlat[ch] = $urandom_range(lat_hi, lat_lo);
               if (rcnt[ch] > rlat[ch]) begin
                  mif.read_ready[ch] = 1'b1;
                  mif.read_data[ch]  = mem_arr[mif.read_address[ch]];
               end else begin
                  mif.read_ready[ch] = 1'b0;
               end
            end else begin
               rcnt[ch] = 0;
               mif.read_ready[ch] = 1'b0;
            end
            if (mif.write_valid[ch] && !mem_hold) begin
               wcnt[ch]++;
               if (wcnt[ch] == 1) wlat[ch] = $urandom_range(lat_hi, lat_lo);
               if (wcnt[ch] > wlat[ch]) begin
                  if (!mif.write_ready[ch]) mem_arr[mif.write_address[ch]] = mif.write_data[ch];
                  mif.write_ready[ch] = 1'b1;
               end else begin
                  mif.write_ready[ch] = 1'b0;
               end
            end else begin
               wcnt[ch] = 0;
               mif.write_ready[ch] = 1'b0;
            end
         end
      end
   end

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
      $fatal(1, "watchdog expired");
   end

   initial begin : main
      int order [$];
      int chq [$];
      logic [NCH-1:0] prev;
      int n_done;
      bit got;
      int cst [NC];
      int gap [NC];
      int wt [NC];
      bit cop_wr [NC];
      logic [AB-1:0] caddr [NC];
      logic [DB-1:0] cdata [NC];

      reset = 1'b0;
      cif.read_valid    = '0;
      cif.read_address  = '0;
      cif.write_valid   = '0;
      cif.write_address = '0;
      cif.write_data    = '0;
      for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
      #1;
      check_zero("reset");
      repeat (2) @(posedge clk);
      #3;
      reset = 1'b1;
      tick();

      // Contention: all consumers read at once, one-cycle memory.
      for (int c = 0; c < NC; c++) begin
         cif.read_address[c] = {3'(c), 5'(c)};
         cif.read_valid[c]   = 1'b1;
      end
      prev = '0;
      n_done = 0;
      for (int t = 0; t < 80 && n_done < NC; t++) begin
         tick();
         for (int ch = 0; ch < NCH; ch++) begin
            if (mif.read_valid[ch] && !prev[ch]) begin
               order.push_back(int'(mif.read_address[ch][7:5]));
               chq.push_back(ch);
            end
         end
         prev = mif.read_valid;
         if (mif.read_valid[0] && mif.read_valid[1])
            check("cont_distinct", 64'(mif.read_address[0][7:5] == mif.read_address[1][7:5]), 64'(0));
         for (int c = 0; c < NC; c++) begin
            if (cif.read_ready[c] && cif.read_valid[c]) begin
               check("cont_data", 64'(cif.read_data[c]), 64'(ref_mem[cif.read_address[c]]));
               cif.read_valid[c] = 1'b0;
               n_done++;
            end
         end
      end
      check("cont_done", 64'(n_done), 64'(NC));
      check("cont_grants", 64'(order.size()), 64'(NC));
      for (int k = 0; k < order.size(); k++) begin
         check("cont_order", 64'(order[k]), 64'(k));
         check("cont_chan", 64'(chq[k]), 64'(k % NCH));
      end
      tick(); tick();

      // Single read: consumer 3, address 0x10.
      cif.read_address[3] = 8'h10;
      cif.read_valid[3]   = 1'b1;
      tick();
      check("rd_mvalid", 64'(mif.read_valid[0]), 64'(1));
      check("rd_maddr", 64'(mif.read_address[0]), 64'(8'h10));
      check("rd_early_ready", 64'(cif.read_ready[3]), 64'(0));
      tick();
      check("rd_ready", 64'(cif.read_ready[3]), 64'(1));
      check("rd_data", 64'(cif.read_data[3]), 64'(32'h0001_8000));
      check("rd_mvalid_drop", 64'(mif.read_valid[0]), 64'(0));
      tick();
      check("rd_ready_held", 64'(cif.read_ready[3]), 64'(1));
      cif.read_valid[3] = 1'b0;
      tick();
      check("rd_release", 64'(cif.read_ready[3]), 64'(0));
      check("rd_data_held", 64'(cif.read_data[3]), 64'(32'h0001_8000));
      tick();

      // Write: consumer 5 writes 0xDEADBEEF to 0x22.
      cif.write_address[5] = 8'h22;
      cif.write_data[5]    = 32'hDEAD_BEEF;
      cif.write_valid[5]   = 1'b1;
`ifdef DATA_MEM_ARB_WRITE_EN
      lat_lo = 3; lat_hi = 3;
      tick();
      got = 1'b0;
      for (int i = 0; i < 10 && !got; i++) begin
         if (cif.write_ready[5]) got = 1'b1;
         else begin
            check("wr_mvalid", 64'(mif.write_valid[0]), 64'(1));
            check("wr_maddr", 64'(mif.write_address[0]), 64'(8'h22));
            check("wr_mdata", 64'(mif.write_data[0]), 64'(32'hDEAD_BEEF));
            tick();
         end
      end
      check("wr_ready", 64'(got), 64'(1));
      tick();
      check("wr_ready_held", 64'(cif.write_ready[5]), 64'(1));
      cif.write_valid[5] = 1'b0;
      tick();
      check("wr_release", 64'(cif.write_ready[5]), 64'(0));
      check("wr_committed", 64'(mem_arr[8'h22]), 64'(32'hDEAD_BEEF));
      ref_mem[8'h22] = 32'hDEAD_BEEF;
      lat_lo = 0; lat_hi = 0;
`else
      for (int i = 0; i < 5; i++) begin
         tick();
         check("wr_off_mvalid", 64'(mif.write_valid), 64'(0));
         check("wr_off_ready", 64'(cif.write_ready[5]), 64'(0));
      end
      cif.write_valid[5] = 1'b0;
`endif
      tick();

      // Same consumer requests read and write together: read goes first.
      cif.read_address[2]  = 8'h45;
      cif.write_address[2] = 8'h4A;
      cif.write_data[2]    = 32'h1234_5678;
      cif.read_valid[2]    = 1'b1;
      cif.write_valid[2]   = 1'b1;
      tick();
      check("rw_mrvalid", 64'(mif.read_valid[0]), 64'(1));
      check("rw_mraddr", 64'(mif.read_address[0]), 64'(8'h45));
      check("rw_mwvalid", 64'(mif.write_valid), 64'(0));
      tick();
      check("rw_rready", 64'(cif.read_ready[2]), 64'(1));
      check("rw_rdata", 64'(cif.read_data[2]), 64'(ref_mem[8'h45]));
      check("rw_wready", 64'(cif.write_ready[2]), 64'(0));
      cif.read_valid[2] = 1'b0;
      got = 1'b0;
      for (int i = 0; i < 10 && !got; i++) begin
         tick();
         if (cif.write_ready[2]) got = 1'b1;
      end
      check("rw_wr_after_rd", 64'(got), 64'(WR_EN));
      if (got) ref_mem[8'h4A] = 32'h1234_5678;
      cif.write_valid[2] = 1'b0;
      tick(); tick();
      if (WR_EN) check("rw_committed", 64'(mem_arr[8'h4A]), 64'(32'h1234_5678));

      // Slow memory: ready withheld for 10 cycles.
      mem_hold = 1'b1;
      cif.read_address[4] = 8'h90;
      cif.read_valid[4]   = 1'b1;
      tick();
      for (int i = 0; i < 10; i++) begin
         check("slow_mvalid", 64'(mif.read_valid[0]), 64'(1));
         check("slow_maddr", 64'(mif.read_address[0]), 64'(8'h90));
         check("slow_no_ready", 64'(cif.read_ready[4]), 64'(0));
         tick();
      end
      mem_hold = 1'b0;
      got = 1'b0;
      for (int i = 0; i < 6 && !got; i++) begin
         tick();
         if (cif.read_ready[4]) got = 1'b1;
      end
      check("slow_ready", 64'(got), 64'(1));
      check("slow_data", 64'(cif.read_data[4]), 64'(ref_mem[8'h90]));
      cif.read_valid[4] = 1'b0;
      tick(); tick();

      // Reset while both channels wait on memory.
      mem_hold = 1'b1;
      cif.read_address[4] = 8'h88;
      cif.read_address[6] = 8'hC8;
      cif.read_valid[4]   = 1'b1;
      cif.read_valid[6]   = 1'b1;
      tick();
      check("rst_ch1_busy", 64'(mif.read_valid[1]), 64'(1));
      #2;
      reset = 1'b0;
      #1;
      check_zero("rst_mid");
      cif.read_valid = '0;
      mem_hold = 1'b0;
      @(posedge clk);
      #3;
      reset = 1'b1;
      cif.read_address[0] = 8'h03;
      cif.read_address[7] = 8'hE3;
      cif.read_valid[0]   = 1'b1;
      cif.read_valid[7]   = 1'b1;
      tick();
      check("rst_first_ch0", 64'(mif.read_address[0][7:5]), 64'(0));
      check("rst_first_ch1", 64'(mif.read_address[1][7:5]), 64'(7));
      n_done = 0;
      for (int i = 0; i < 10 && n_done < 2; i++) begin
         tick();
         for (int c = 0; c < NC; c++) begin
            if (cif.read_ready[c] && cif.read_valid[c]) begin
               check("rst_data", 64'(cif.read_data[c]), 64'(ref_mem[cif.read_address[c]]));
               cif.read_valid[c] = 1'b0;
               n_done++;
            end
         end
      end
      check("rst_served", 64'(n_done), 64'(2));
      tick(); tick();

      // Randomized traffic: private address region per consumer, random memory latency.
      lat_lo = 0; lat_hi = 3;
      for (int c = 0; c < NC; c++) begin
         cst[c] = 0; gap[c] = $urandom_range(3, 0); wt[c] = 0;
         cop_wr[c] = 1'b0; caddr[c] = '0; cdata[c] = '0;
      end
      for (int cyc = 0; cyc < 1500; cyc++) begin
         tick();
         if ((mif.read_valid[0] | mif.write_valid[0]) && (mif.read_valid[1] | mif.write_valid[1]))
            check("rnd_distinct",
                  64'((mif.read_valid[0] ? mif.read_address[0][7:5] : mif.write_address[0][7:5]) ==
                      (mif.read_valid[1] ? mif.read_address[1][7:5] : mif.write_address[1][7:5])),
                  64'(0));
         for (int c = 0; c < NC; c++) begin
            case (cst[c])
               0: if (cyc < 1200) begin
                  if (gap[c] > 0) gap[c]--;
                  else begin
                     cop_wr[c] = WR_EN ? 1'($urandom_range(1, 0)) : 1'b0;
                     caddr[c]  = {3'(c), 5'($urandom_range(31, 0))};
                     cdata[c]  = $urandom;
                     wt[c]     = 0;
                     if (cop_wr[c]) begin
                        cif.write_address[c] = caddr[c];
                        cif.write_data[c]    = cdata[c];
                        cif.write_valid[c]   = 1'b1;
                     end else begin
                        cif.read_address[c] = caddr[c];
                        cif.read_valid[c]   = 1'b1;
                     end
                     cst[c] = 1;
                  end
               end
               1: begin
                  if (cop_wr[c] ? cif.write_ready[c] : cif.read_ready[c]) begin
                     if (cop_wr[c]) ref_mem[caddr[c]] = cdata[c];
                     else check("rnd_rdata", 64'(cif.read_data[c]), 64'(ref_mem[caddr[c]]));
                     cif.read_valid[c]  = 1'b0;
                     cif.write_valid[c] = 1'b0;
                     cst[c] = 2;
                  end else if (++wt[c] > 120) begin
                     check("rnd_starved", 64'(cop_wr[c] ? cif.write_ready[c] : cif.read_ready[c]), 64'(1));
                     cif.read_valid[c]  = 1'b0;
                     cif.write_valid[c] = 1'b0;
                     cst[c] = 2;
                  end
               end
               default: begin
                  check("rnd_release", 64'(cif.read_ready[c] | cif.write_ready[c]), 64'(0));
                  cst[c] = 0;
                  gap[c] = $urandom_range(4, 1);
               end
            endcase
         end
      end
      for (int c = 0; c < NC; c++) check("rnd_drained", 64'(cst[c]), 64'(0));
      for (int a = 0; a < 256; a++)
         if (mem_arr[a] !== ref_mem[a]) check("rnd_mem_image", 64'(mem_arr[a]), 64'(ref_mem[a]));

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
